// File: rtl/aes_pkg.sv
// aes_pkg: shared types, limits and ShiftRows tables
// for the column-serial AES/Rijndael datapath.
package aes_pkg;

    localparam int NB_MAX = 8;

    // bit n set <=> NB = n is a legal Rijndael block width
    localparam logic [NB_MAX:0] NB_LEGAL = 9'b1_0101_0000;

    typedef logic [31:0] col_t;

    typedef enum logic {
        FWD = 1'b0,
        INV = 1'b1
    } state_mode_e;

    function automatic int row_offset(input int nb, input int r);
        int off;
        off = 0;
        unique case (r)
            1:       off = 1;
            2:       off = (nb == 8) ? 3 : 2;
            3:       off = (nb == 8) ? 4 : 3;
            default: off = 0;
        endcase
        return off;
    endfunction

    function automatic bit nb_is_legal(input int nb);
        bit ok;
        ok = 1'b0;
        if (nb >= 0 && nb <= NB_MAX)
            ok = NB_LEGAL[nb[3:0]];
        return ok;
    endfunction

endpackage

// File: rtl/rows_rotate_nb.sv
// rows_rotate_nb: picks one ShiftRows-permuted column
// out of an NB-column state, forward or inverse.
module rows_rotate_nb
    import aes_pkg::*;
#(
    parameter int NB = 4,
    localparam int CW = $clog2(NB)
) (
    input  col_t          bank [NB],
    input  logic [CW-1:0] col,
    input  state_mode_e   mode,
    output col_t          out_col
);

    int src;

    // each output row byte comes from the rotated source column
    always_comb begin
        out_col = '0;
        src     = 0;
        for (int r = 0; r < 4; r++) begin
            if (mode == INV)
                src = (int'(col) + NB - row_offset(NB, r)) % NB;
            else
                src = (int'(col) + row_offset(NB, r)) % NB;
            out_col[8*r +: 8] = bank[src[CW-1:0]][8*r +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: ping-pong buffered, column-serial
// ShiftRows engine with valid/ready on both sides.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB       = 4,
    parameter int OUT_GATE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_mode
);

    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    col_t          bank [2][NB];
    logic [1:0]    full;
    logic [1:0]    mode;
    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] wr_col;
    logic [CW-1:0] rd_col;
    col_t          rd_sel [NB];
    col_t          perm;
    logic          in_beat;
    logic          out_beat;

    assign in_ready  = !full[wr_bank] && !rst;
    assign out_valid = full[rd_bank];
    assign in_beat   = in_valid && in_ready;
    assign out_beat  = out_valid && out_ready;
    assign out_last  = out_valid && (rd_col == LAST);
    assign out_mode  = mode[rd_bank];

    // fill and drain never target the same bank: fill
    // needs it empty, drain needs it full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            mode    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_col  <= '0;
            rd_col  <= '0;
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < NB; c++)
                    bank[b][c] <= '0;
        end else if (flush) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_col  <= '0;
            rd_col  <= '0;
        end else begin
            if (in_beat) begin
                bank[wr_bank][wr_col] <= in_data;
                if (wr_col == '0)
                    mode[wr_bank] <= in_mode;
                if (wr_col == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                    wr_col        <= '0;
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            if (out_beat) begin
                if (rd_col == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                    rd_col        <= '0;
                end else begin
                    rd_col <= rd_col + CW'(1);
                end
            end
        end
    end

    // present the draining bank to the permutation network
    always_comb begin
        for (int c = 0; c < NB; c++)
            rd_sel[c] = rd_bank ? bank[1][c] : bank[0][c];
    end

    rows_rotate_nb #(
        .NB (NB)
    ) u_rot (
        .bank    (rd_sel),
        .col     (rd_col),
        .mode    (state_mode_e'(mode[rd_bank])),
        .out_col (perm)
    );

    assign out_data = (OUT_GATE != 0 && !out_valid) ? '0 : perm;

endmodule
